// File: rtl/bowling_game_score_keeper.sv
// Ten-pin bowling score keeper.
// Each rising edge of the asynchronous UPD strobe registers one throw of N pins.
// Strike and spare bonuses are applied as the bonus throws arrive. The running
// score is shown on three 7-segment digits.
// Ports:
//   seg   - {hundreds, tens, units}. Each byte: bit0=a .. bit6=g, bit7=dp (always 0).
//   Done  - high once the game is complete; held until reset.
//   N     - pins knocked down on this throw (0..10).
//   UPD   - throw strobe, asynchronous to clock; its rising edge registers N.
//   clock - system clock, rising edge.
//   reset - synchronous, active-high; clears the game.
module bowling_game_score_keeper (
    output logic [23:0] seg,
    output logic        Done,
    input  logic [3:0]  N,
    input  logic        UPD,
    input  logic        clock,
    input  logic        reset
);

    logic       upd_s1_q, upd_s2_q, upd_d_q;
    logic       upd_edge;

    logic [8:0] score_q, score_d;
    logic [3:0] frame_q, frame_d;
    logic [1:0] ball_q, ball_d;   // 3 = extra throw in frame 10
    logic [3:0] first_q, first_d; // ball-1 count of the current frame
    logic [1:0] bonus_next_q, bonus_next_d;
    logic [1:0] bonus_after_q, bonus_after_d;
    logic       done_q, done_d;

    logic       valid;
    logic       strike, spare;
    logic [4:0] pin_sum;
    logic [1:0] mult;
    logic [5:0] points;

    // Synchronizer flops preset high in reset so that a UPD held high across
    // reset is not seen as a fresh edge.
    assign upd_edge = upd_s2_q & ~upd_d_q;

    assign pin_sum = {1'b0, first_q} + {1'b0, N};
    assign mult    = 2'd1 + bonus_next_q;
    assign points  = 6'(N) * 6'(mult);

    always_comb begin
        score_d       = score_q;
        frame_d       = frame_q;
        ball_d        = ball_q;
        first_d       = first_q;
        bonus_next_d  = bonus_next_q;
        bonus_after_d = bonus_after_q;
        done_d        = done_q;

        valid  = upd_edge && !done_q && (N <= 4'd10) &&
                 !((frame_q < 4'd10) && (ball_q == 2'd2) && (N > (4'd10 - first_q)));
        strike = (frame_q < 4'd10) && (ball_q == 2'd1) && (N == 4'd10);
        spare  = (frame_q < 4'd10) && (ball_q == 2'd2) && (pin_sum == 5'd10);

        if (valid) begin
            score_d       = score_q + 9'(points);
            bonus_next_d  = bonus_after_q + {1'b0, strike} + {1'b0, spare};
            bonus_after_d = {1'b0, strike};

            if (frame_q < 4'd10) begin
                if ((ball_q == 2'd1) && !strike) begin
                    ball_d  = 2'd2;
                    first_d = N;
                end else begin
                    frame_d = frame_q + 4'd1;
                    ball_d  = 2'd1;
                end
            end else begin
                unique case (ball_q)
                    2'd1: begin
                        first_d = N;
                        ball_d  = 2'd2;
                    end
                    2'd2: begin
                        // Strike or spare in frame 10 earns one more throw.
                        if ((first_q == 4'd10) || (pin_sum == 5'd10)) begin
                            ball_d = 2'd3;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                    default: done_d = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            upd_s1_q      <= 1'b1;
            upd_s2_q      <= 1'b1;
            upd_d_q       <= 1'b1;
            score_q       <= 9'd0;
            frame_q       <= 4'd1;
            ball_q        <= 2'd1;
            first_q       <= 4'd0;
            bonus_next_q  <= 2'd0;
            bonus_after_q <= 2'd0;
            done_q        <= 1'b0;
        end else begin
            upd_s1_q      <= UPD;
            upd_s2_q      <= upd_s1_q;
            upd_d_q       <= upd_s2_q;
            score_q       <= score_d;
            frame_q       <= frame_d;
            ball_q        <= ball_d;
            first_q       <= first_d;
            bonus_next_q  <= bonus_next_d;
            bonus_after_q <= bonus_after_d;
            done_q        <= done_d;
        end
    end

    // Digit to segment byte: {dp, g, f, e, d, c, b, a}.
    function automatic logic [7:0] seg_enc(input logic [8:0] digit);
        logic [7:0] s;
        case (digit)
            9'd0:    s = 8'h3F;
            9'd1:    s = 8'h06;
            9'd2:    s = 8'h5B;
            9'd3:    s = 8'h4F;
            9'd4:    s = 8'h66;
            9'd5:    s = 8'h6D;
            9'd6:    s = 8'h7D;
            9'd7:    s = 8'h07;
            9'd8:    s = 8'h7F;
            9'd9:    s = 8'h6F;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    logic [8:0] hund_w, tens_w, unit_w;

    assign hund_w = score_q / 9'd100;
    assign tens_w = (score_q % 9'd100) / 9'd10;
    assign unit_w = score_q % 9'd10;

    assign seg  = {seg_enc(hund_w), seg_enc(tens_w), seg_enc(unit_w)};
    assign Done = done_q;

endmodule

// File: tb/tb_bowling_game_score_keeper.sv
module tb_bowling_game_score_keeper;

    logic [23:0] seg;
    logic        Done;
    logic [3:0]  N;
    logic        UPD;
    logic        clock;
    logic        reset;

    int checks;
    int failures;

    bowling_game_score_keeper dut (
        .seg   (seg),
        .Done  (Done),
        .N     (N),
        .UPD   (UPD),
        .clock (clock),
        .reset (reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // abcdefg patterns for digits 0..9.
    logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                             7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    function automatic logic [7:0] digit_byte(input int d);
        logic [7:0] b;
        logic [6:0] p;
        p = pat[d];
        b = 8'h00;
        for (int k = 0; k < 7; k++) b[k] = p[6-k];
        return b;
    endfunction

    function automatic logic [23:0] seg_of(input int s);
        return {digit_byte(s / 100), digit_byte((s / 10) % 10), digit_byte(s % 10)};
    endfunction

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic throw_pins(input int n, input int hold);
        N   = 4'(n);
        UPD = 1'b1;
        repeat (hold) @(posedge clock);
        #1 UPD = 1'b0;
        repeat (5) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
    endtask

    int mixed_throws [18] = '{4, 5, 7, 3, 2, 6, 10, 10, 1, 9, 10, 3, 1, 3, 3, 9, 1, 10};
    int mixed_scores [18] = '{4, 9, 16, 19, 23, 29, 39, 59, 62, 80, 100, 106, 108, 111, 114,
                              123, 124, 134};
    int strike_scores [12] = '{10, 30, 60, 90, 120, 150, 180, 210, 240, 270, 290, 300};

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        UPD      = 1'b0;
        N        = 4'd0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_seg", seg, seg_of(0));
        check("reset_done", {23'd0, Done}, 24'd0);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Mixed game.
        for (int i = 0; i < 18; i++) begin
            throw_pins(mixed_throws[i], 1);
            check($sformatf("mixed_score_%0d", i), seg, seg_of(mixed_scores[i]));
            if (i == 16) check("mixed_done_early", {23'd0, Done}, 24'd0);
        end
        check("mixed_done", {23'd0, Done}, 24'd1);
        throw_pins(5, 1);
        check("mixed_after_done", seg, seg_of(134));

        // Reset mid-game at 59.
        do_reset();
        for (int i = 0; i < 8; i++) throw_pins(mixed_throws[i], 1);
        check("mid_score_59", seg, seg_of(59));
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid_reset_seg", seg, seg_of(0));
        check("mid_reset_done", {23'd0, Done}, 24'd0);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Perfect game.
        for (int i = 0; i < 12; i++) begin
            throw_pins(10, 1);
            check($sformatf("strike_score_%0d", i), seg, seg_of(strike_scores[i]));
        end
        check("perfect_done", {23'd0, Done}, 24'd1);

        // Open game of twenty 4s.
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            throw_pins(4, 1);
            check($sformatf("open_score_%0d", i), seg, seg_of(4 * i));
            if (i == 19) check("open_done_19", {23'd0, Done}, 24'd0);
        end
        check("open_done_20", {23'd0, Done}, 24'd1);
        throw_pins(4, 1);
        check("open_after_done", seg, seg_of(80));

        // Invalid throws leave score, frame and ball unchanged.
        do_reset();
        throw_pins(7, 1);
        throw_pins(11, 1);
        check("inv_n11", seg, seg_of(7));
        throw_pins(5, 1);
        check("inv_sum", seg, seg_of(7));
        throw_pins(3, 1);
        check("inv_spare", seg, seg_of(10));
        throw_pins(4, 1);
        check("inv_bonus", seg, seg_of(18));

        // UPD held high for 10 clocks counts one throw.
        do_reset();
        throw_pins(4, 10);
        check("held_one_throw", seg, seg_of(4));
        throw_pins(5, 1);
        check("pulse_one_throw", seg, seg_of(9));

        // UPD held high across reset.
        N   = 4'd3;
        UPD = 1'b1;
        repeat (3) @(posedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check("held_across_reset", seg, seg_of(0));
        UPD = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        throw_pins(3, 1);
        check("fresh_edge_after_reset", seg, seg_of(3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
